// File: rtl/bike_counter_bank.sv
// Bank of independent up/down counters, each bounded to [0, MAX_VALUE].
// Every channel saturates or wraps at the bounds, supports synchronous
// clear and load, and reports boundary flags plus a registered wrap event.
module bike_counter_bank #(
  parameter int CHANNELS  = 4,
  parameter int SIZE      = 5,
  parameter int MAX_VALUE = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [CHANNELS-1:0]      enable,
  input  logic [CHANNELS-1:0]      dir,
  input  logic [CHANNELS-1:0]      wrap_mode,
  input  logic [CHANNELS-1:0]      clear,
  input  logic [CHANNELS-1:0]      load,
  input  logic [CHANNELS*SIZE-1:0] load_value,
  output logic [CHANNELS*SIZE-1:0] cnt_out,
  output logic [CHANNELS-1:0]      at_max,
  output logic [CHANNELS-1:0]      at_zero,
  output logic [CHANNELS-1:0]      wrap_pulse,
  output logic                     all_max
);

  // Bound held one bit wider than the register so compares never overflow.
  localparam logic [SIZE:0] MAX_EXT = (SIZE+1)'(MAX_VALUE);

  // Load data above the bound is clamped to the bound.
  function automatic logic [SIZE-1:0] clamp_load(input logic [SIZE-1:0] v);
    if ({1'b0, v} > MAX_EXT) return MAX_EXT[SIZE-1:0];
    else return v;
  endfunction

  // One enabled step; result is {wrap_event, next_count}. The bound is
  // checked before adding, so the carry bit of the sum is always zero and
  // doubles as a cleared wrap flag.
  function automatic logic [SIZE:0] step(input logic [SIZE-1:0] c,
                                         input logic d,
                                         input logic w);
    logic [SIZE:0] e;
    e = {1'b0, c};
    if (!d) begin
      if (e < MAX_EXT) return e + (SIZE+1)'(1);
      else if (w)      return {1'b1, {SIZE{1'b0}}};
      else             return e;
    end else begin
      if (e != '0)     return e - (SIZE+1)'(1);
      else if (w)      return {1'b1, MAX_EXT[SIZE-1:0]};
      else             return e;
    end
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SIZE-1:0] cnt_p0;
    logic            wrap_p0;

    // Per-channel count register and wrap event: reset > clear > load > step.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt_p0  <= '0;
        wrap_p0 <= 1'b0;
      end else if (clear[g]) begin
        cnt_p0  <= '0;
        wrap_p0 <= 1'b0;
      end else if (load[g]) begin
        cnt_p0  <= clamp_load(load_value[g*SIZE +: SIZE]);
        wrap_p0 <= 1'b0;
      end else if (enable[g]) begin
        {wrap_p0, cnt_p0} <= step(cnt_p0, dir[g], wrap_mode[g]);
      end else begin
        wrap_p0 <= 1'b0;
      end
    end

    assign cnt_out[g*SIZE +: SIZE] = cnt_p0;
    assign at_max[g]     = (cnt_p0 == MAX_EXT[SIZE-1:0]);
    assign at_zero[g]    = (cnt_p0 == '0);
    assign wrap_pulse[g] = wrap_p0;
  end

  assign all_max = &at_max;

endmodule

// File: tb/tb_bike_counter_bank.sv
// Self-checking bench for bike_counter_bank: directed scenarios followed by
// random traffic, all compared against an integer reference model.
module tb_bike_counter_bank;

  localparam int CH = 4;
  localparam int SZ = 5;
  localparam int MX = 20;
  localparam int MX2 = 15;

  logic clk = 1'b0;
  logic resetn;
  logic [CH-1:0] enable, dir, wrap_mode, clear, load;
  logic [CH*SZ-1:0] load_value;
  logic [CH*SZ-1:0] cnt_out;
  logic [CH-1:0] at_max, at_zero, wrap_pulse;
  logic all_max;

  logic en2, dir2, wm2, clr2, ld2;
  logic [3:0] lv2, cnt2;
  logic am2, az2, wp2, allm2;

  int checks = 0;
  int failures = 0;
  int mc [CH];
  bit mw [CH];
  int mc2;
  bit mw2;

  always #5 clk = ~clk;

  bike_counter_bank #(.CHANNELS(CH), .SIZE(SZ), .MAX_VALUE(MX)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dir(dir),
    .wrap_mode(wrap_mode), .clear(clear), .load(load),
    .load_value(load_value), .cnt_out(cnt_out), .at_max(at_max),
    .at_zero(at_zero), .wrap_pulse(wrap_pulse), .all_max(all_max)
  );

  bike_counter_bank #(.CHANNELS(1), .SIZE(4), .MAX_VALUE(MX2)) dut2 (
    .clk(clk), .resetn(resetn), .enable(en2), .dir(dir2),
    .wrap_mode(wm2), .clear(clr2), .load(ld2),
    .load_value(lv2), .cnt_out(cnt2), .at_max(am2),
    .at_zero(az2), .wrap_pulse(wp2), .all_max(allm2)
  );

  // Next count of one channel from the rules, with its wrap event.
  function automatic int next_cnt(int c, bit rn, bit clr, bit ld, int lv,
                                  bit en, bit d, bit w, int mx, output bit wp);
    wp = 1'b0;
    if (!rn)  return 0;
    if (clr)  return 0;
    if (ld)   return (lv > mx) ? mx : lv;
    if (!en)  return c;
    if (!d) begin
      if (c < mx) return c + 1;
      if (w) begin wp = 1'b1; return 0; end
      return c;
    end
    if (c > 0) return c - 1;
    if (w) begin wp = 1'b1; return mx; end
    return c;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit am_all;
    am_all = 1'b1;
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("cnt%0d", i), int'(cnt_out[i*SZ +: SZ]), mc[i]);
      chk($sformatf("at_max%0d", i), int'(at_max[i]), int'(mc[i] == MX));
      chk($sformatf("at_zero%0d", i), int'(at_zero[i]), int'(mc[i] == 0));
      chk($sformatf("wrap_pulse%0d", i), int'(wrap_pulse[i]), int'(mw[i]));
      if (mc[i] != MX) am_all = 1'b0;
    end
    chk("all_max", int'(all_max), int'(am_all));
    chk("s4_cnt", int'(cnt2), mc2);
    chk("s4_wrap", int'(wp2), int'(mw2));
    chk("s4_at_max", int'(am2), int'(mc2 == MX2));
    chk("s4_at_zero", int'(az2), int'(mc2 == 0));
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic tick();
    bit rn;
    bit [CH-1:0] en, d, w, cl, ld;
    bit [CH*SZ-1:0] lv;
    rn = resetn; en = enable; d = dir; w = wrap_mode; cl = clear; ld = load;
    lv = load_value;
    @(posedge clk);
    for (int i = 0; i < CH; i++)
      mc[i] = next_cnt(mc[i], rn, cl[i], ld[i], int'(lv[i*SZ +: SZ]),
                       en[i], d[i], w[i], MX, mw[i]);
    mc2 = next_cnt(mc2, rn, clr2, ld2, int'(lv2), en2, dir2, wm2, MX2, mw2);
    #1;
    compare_all();
  endtask

  task automatic idle();
    enable = '0; dir = '0; wrap_mode = '0; clear = '0; load = '0;
    load_value = '0;
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin mc[i] = 0; mw[i] = 0; end
    mc2 = 0; mw2 = 0;
    idle();
    en2 = 1'b1; dir2 = 1'b0; wm2 = 1'b1; clr2 = 1'b0; ld2 = 1'b0; lv2 = '0;
    resetn = 1'b0;
    tick(); tick();
    chk("reset_at_zero", int'(at_zero), 15);
    resetn = 1'b1;

    // ch0 up, saturating, 25 edges: 1..20 then hold
    enable[0] = 1'b1;
    for (int k = 0; k < 25; k++) tick();
    chk("ch0_sat_hold", int'(cnt_out[0 +: SZ]), 20);
    idle();

    // ch1 wrap: load 19, then 3 enabled edges -> 20, 0, 1
    load[1] = 1'b1; load_value[1*SZ +: SZ] = 5'd19;
    tick();
    idle();
    enable[1] = 1'b1; wrap_mode[1] = 1'b1;
    tick(); tick();
    chk("ch1_wrap_pulse", int'(wrap_pulse[1]), 1);
    tick();
    chk("ch1_after_wrap", int'(cnt_out[1*SZ +: SZ]), 1);
    idle();

    // ch2 down from 0: wrap to 20, then saturate at 0
    clear[2] = 1'b1; tick(); idle();
    enable[2] = 1'b1; dir[2] = 1'b1; wrap_mode[2] = 1'b1;
    tick();
    chk("ch2_down_wrap", int'(cnt_out[2*SZ +: SZ]), 20);
    idle(); clear[2] = 1'b1; tick(); idle();
    enable[2] = 1'b1; dir[2] = 1'b1;
    tick(); tick();
    chk("ch2_down_sat", int'(at_zero[2]), 1);
    idle();

    // ch3 load clamp, clear beats load, load beats enable
    load[3] = 1'b1; load_value[3*SZ +: SZ] = 5'd31; tick();
    chk("ch3_clamp", int'(cnt_out[3*SZ +: SZ]), 20);
    clear[3] = 1'b1; tick();
    idle(); load[3] = 1'b1; enable[3] = 1'b1; load_value[3*SZ +: SZ] = 5'd5;
    tick();
    chk("ch3_load_en", int'(cnt_out[3*SZ +: SZ]), 5);
    idle();

    // clear+enable at wrap boundary: 0 and no pulse
    load[0] = 1'b1; load_value[0 +: SZ] = 5'd20; tick(); idle();
    clear[0] = 1'b1; enable[0] = 1'b1; wrap_mode[0] = 1'b1; tick();
    chk("clr_en_wrap", int'(wrap_pulse[0]), 0);
    idle();

    // all channels up from 0: all_max after exactly 20 edges
    clear = '1; tick(); idle();
    enable = '1;
    for (int k = 0; k < 19; k++) tick();
    chk("all_max_19", int'(all_max), 0);
    tick();
    chk("all_max_20", int'(all_max), 1);
    idle();

    // reset mid-count overrides everything
    clear = '1; tick(); idle(); enable = '1; wrap_mode = '1;
    for (int k = 0; k < 7; k++) tick();
    resetn = 1'b0; load = '1; load_value = '1; tick();
    chk("mid_reset_cnt", int'(cnt_out), 0);
    resetn = 1'b1; idle();

    // random traffic on both instances
    for (int k = 0; k < 400; k++) begin
      resetn = ($urandom_range(0, 49) != 0);
      enable = CH'($urandom); dir = CH'($urandom); wrap_mode = CH'($urandom);
      clear = CH'($urandom) & CH'($urandom) & CH'($urandom);
      load = CH'($urandom) & CH'($urandom);
      load_value = (CH*SZ)'($urandom);
      en2 = ($urandom_range(0, 3) != 0); dir2 = 1'($urandom);
      wm2 = ($urandom_range(0, 3) != 0);
      clr2 = ($urandom_range(0, 15) == 0); ld2 = ($urandom_range(0, 7) == 0);
      lv2 = 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
